// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BEATS_DEF  = 16;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beat_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int GRANT_W = grant_w(N_REQ_DEF);
    localparam int BEAT_W  = beat_w(MAX_BEATS_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake bundle plus the FIFO write-side signals it feeds.
interface fifo_wr_arbiter_if
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        full;
    logic                        w_en;
    logic [DATA_WIDTH-1:0]       w_data;

    modport master (
        input  req_valid, req_data, req_last, full,
        output req_ready, w_en, w_data
    );

    modport slave (
        output req_valid, req_data, req_last, full,
        input  req_ready, w_en, w_data
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above start, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int ofs);
        return W'((int'(base) + ofs) % N);
    endfunction

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_idx(start, i)]) begin
                idx = wrap_idx(start, i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing the async FIFO write port among N_REQ requesters.
//
//   state | meaning
//   IDLE  | no lock; pick next requester from rr_ptr, lock on the next edge
//   LOCK  | grant_id owns the write port until its last (or MAX_BEATS-th) beat
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF,
    localparam int GW        = grant_w(N_REQ)
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    fifo_wr_arbiter_if.master     bus,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  pkt_err
);

    localparam int            BW       = beat_w(MAX_BEATS);
    localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BEATS - 1);
    localparam logic [GW-1:0] LAST_ID  = GW'(N_REQ - 1);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            pkt_err_q, pkt_err_d;

    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];
    logic                  valid_g;
    logic                  last_g;
    logic                  accept;
    logic                  hit_max;

    rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .start (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign valid_g = bus.req_valid[grant_q];
    assign last_g  = bus.req_last[grant_q];
    assign accept  = (state_q == LOCK) & valid_g & ~bus.full;
    assign hit_max = (beat_cnt_q == LAST_CNT);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        pkt_err_d  = pkt_err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // An over-long packet is cut here; its tail re-arbitrates as a new packet.
                    if (last_g || hit_max) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                        if (!last_g) begin
                            pkt_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the write port combinationally so nothing leaks out in the reset cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.w_en      = 1'b0;
        bus.w_data    = '0;
        busy          = 1'b0;
        if (!w_rst && state_q == LOCK) begin
            busy                   = 1'b1;
            bus.req_ready[grant_q] = ~bus.full;
            bus.w_en               = accept;
            if (accept) begin
                bus.w_data = data_arr[grant_q];
            end
        end
    end

    assign grant_id = grant_q;
    assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: beats are tagged {requester, sequence} and matched in order.
module tb_fifo_wr_arbiter;
    import fifo_wr_arb_pkg::*;

    localparam int NR = N_REQ_DEF;
    localparam int DW = DATA_WIDTH_DEF;
    localparam int MB = MAX_BEATS_DEF;

    logic               w_clk = 1'b0;
    logic               w_rst = 1'b1;
    logic [GRANT_W-1:0] grant_id;
    logic               busy;
    logic               pkt_err;

    fifo_wr_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW)) bus_if ();

    fifo_wr_arbiter #(
        .N_REQ      (NR),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .bus      (bus_if),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_err  (pkt_err)
    );

    always #5 w_clk = ~w_clk;

    int cyc = 0;
    always @(posedge w_clk) cyc <= cyc + 1;

    logic [8:0]    mem [NR][64];
    int            head [NR];
    int            tail [NR];
    int            seq  [NR];
    logic [NR-1:0] mask;
    logic [7:0]    exp_q [$];
    int            wr_cyc [256];
    int            n_wr = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            b, t0, s0, s1, s2, s3;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input int id, input int s);
        return 8'(((id & 3) << 6) | (s & 63));
    endfunction

    task automatic drive();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i]) begin
                v[i]          = ~mask[i];
                l[i]          = mem[i][head[i]][8];
                d[i*DW +: DW] = mem[i][head[i]][7:0];
            end
        end
        bus_if.req_valid = v;
        bus_if.req_last  = l;
        bus_if.req_data  = d;
    endtask

    task automatic load(input int id, input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            mem[id][tail[id]] = {with_last && (k == n - 1), mk(id, seq[id])};
            seq[id]++;
            tail[id]++;
        end
        drive();
    endtask

    task automatic expect_beats(input int id, input int s, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(id, s + k));
    endtask

    task automatic tick();
        @(posedge w_clk);
        #2;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int left;
        left = budget;
        while (n_wr < target && left > 0) begin
            tick();
            left--;
        end
        if (n_wr < target) chk_eq("timeout_writes", n_wr, target);
    endtask

    task automatic drain();
        wait_wr(n_wr + exp_q.size(), 200);
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        mask = '0;
        bus_if.full = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        flush();
        tick();
        tick();
        w_rst = 1'b0;
        tick();
    endtask

    task automatic monitor();
        logic [7:0] e;
        if (bus_if.w_en) begin
            if (exp_q.size() == 0) begin
                chk_eq("spurious_write", bus_if.w_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("w_data", bus_if.w_data, e);
                chk_eq("grant_at_write", grant_id, e[7:6]);
            end
            if (n_wr < 256) wr_cyc[n_wr] = cyc;
            n_wr++;
        end else begin
            chk_eq("w_data_idle_zero", bus_if.w_data, 0);
        end
        if (bus_if.full) chk_eq("w_en_while_full", bus_if.w_en, 1'b0);
    endtask

    // Requester side: beats retire on the edge after a valid&ready sample.
    initial begin : drv
        logic [NR-1:0] fire;
        forever begin
            @(negedge w_clk);
            fire = bus_if.req_valid & bus_if.req_ready;
            monitor();
            @(posedge w_clk);
            #1;
            for (int i = 0; i < NR; i++) if (fire[i] && head[i] < tail[i]) head[i]++;
            drive();
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < NR; i++) seq[i] = 0;
        flush();
        w_rst = 1'b1;
        repeat (3) tick();
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_w_en", bus_if.w_en, 1'b0);
        chk_eq("rst_ready", bus_if.req_ready, 0);
        chk_eq("rst_grant", grant_id, 0);
        chk_eq("rst_pkt_err", pkt_err, 1'b0);
        w_rst = 1'b0;
        tick();
        chk_eq("post_rst_busy", busy, 1'b0);
        chk_eq("post_rst_w_en", bus_if.w_en, 1'b0);

        // single 3-beat packet from requester 0
        b = n_wr;
        s0 = seq[0];
        load(0, 3, 1'b1);
        t0 = cyc;
        expect_beats(0, s0, 3);
        wait_wr(b + 3, 20);
        chk_eq("t1_latency", wr_cyc[b] - t0, 1);
        chk_eq("t1_back_to_back", wr_cyc[b+2] - wr_cyc[b], 2);
        chk_eq("t1_busy_after_last", busy, 1'b0);
        // rr_ptr now 1: requester 1 must beat requester 0
        s0 = seq[0];
        s1 = seq[1];
        load(0, 1, 1'b1);
        load(1, 1, 1'b1);
        expect_beats(1, s1, 1);
        expect_beats(0, s0, 1);
        drain();

        // fairness: all valid, requester 0 has two packets
        do_reset();
        b = n_wr;
        s0 = seq[0]; s1 = seq[1]; s2 = seq[2]; s3 = seq[3];
        load(0, 2, 1'b1);
        load(0, 2, 1'b1);
        load(1, 2, 1'b1);
        load(2, 2, 1'b1);
        load(3, 2, 1'b1);
        expect_beats(0, s0, 2);
        expect_beats(1, s1, 2);
        expect_beats(2, s2, 2);
        expect_beats(3, s3, 2);
        expect_beats(0, s0 + 2, 2);
        drain();
        for (int k = 0; k < 9; k++) begin
            chk_eq("t2_write_gap", wr_cyc[b+k+1] - wr_cyc[b+k], (k % 2 == 0) ? 1 : 2);
        end

        // full stall mid-packet on requester 2
        b = n_wr;
        s2 = seq[2];
        load(2, 4, 1'b1);
        expect_beats(2, s2, 4);
        wait_wr(b + 1, 20);
        bus_if.full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_eq("t3_w_en_full", bus_if.w_en, 1'b0);
            chk_eq("t3_ready_full", bus_if.req_ready, 0);
            chk_eq("t3_grant_hold", grant_id, 2);
            tick();
        end
        bus_if.full = 1'b0;
        #1;
        chk_eq("t3_resume_w_en", bus_if.w_en, 1'b1);
        chk_eq("t3_resume_ready", bus_if.req_ready, 4'b0100);
        drain();

        // over-long packet from requester 1
        do_reset();
        b = n_wr;
        s1 = seq[1];
        load(1, 20, 1'b1);
        expect_beats(1, s1, MB);
        wait_wr(b + 1, 20);
        chk_eq("t4_pkt_err_early", pkt_err, 1'b0);
        s0 = seq[0]; s2 = seq[2]; s3 = seq[3];
        load(0, 2, 1'b1);
        load(2, 2, 1'b1);
        load(3, 2, 1'b1);
        expect_beats(2, s2, 2);
        expect_beats(3, s3, 2);
        expect_beats(0, s0, 2);
        expect_beats(1, s1 + MB, 20 - MB);
        wait_wr(b + MB, 60);
        chk_eq("t4_busy_after_cut", busy, 1'b0);
        chk_eq("t4_pkt_err_set", pkt_err, 1'b1);
        drain();
        chk_eq("t4_pkt_err_sticky", pkt_err, 1'b1);

        // reset during beat 2 of a 4-beat packet
        b = n_wr;
        s2 = seq[2];
        load(2, 4, 1'b1);
        expect_beats(2, s2, 1);
        wait_wr(b + 1, 20);
        w_rst = 1'b1;
        flush();
        #1;
        chk_eq("t5_w_en_in_rst", bus_if.w_en, 1'b0);
        tick();
        chk_eq("t5_busy", busy, 1'b0);
        chk_eq("t5_w_en", bus_if.w_en, 1'b0);
        chk_eq("t5_grant", grant_id, 0);
        chk_eq("t5_pkt_err", pkt_err, 1'b0);
        chk_eq("t5_ready", bus_if.req_ready, 0);
        w_rst = 1'b0;
        s1 = seq[1];
        s3 = seq[3];
        load(3, 1, 1'b1);
        load(1, 2, 1'b1);
        expect_beats(1, s1, 2);
        expect_beats(3, s3, 1);
        drain();

        // requester 3 drops valid mid-packet while requester 0 waits
        b = n_wr;
        s3 = seq[3];
        load(3, 4, 1'b1);
        expect_beats(3, s3, 4);
        wait_wr(b + 1, 20);
        mask[3] = 1'b1;
        drive();
        s0 = seq[0];
        load(0, 2, 1'b1);
        expect_beats(0, s0, 2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_eq("t6_w_en_gap", bus_if.w_en, 1'b0);
            chk_eq("t6_grant_hold", grant_id, 3);
            chk_eq("t6_busy_hold", busy, 1'b1);
            tick();
        end
        mask[3] = 1'b0;
        drive();
        #1;
        chk_eq("t6_resume_w_en", bus_if.w_en, 1'b1);
        chk_eq("t6_resume_grant", grant_id, 3);
        drain();

        chk_eq("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
